cv32e40p_ft_err_manager: RTL and testbench

Consumer side of the triplicated-replica voter interface. Takes the per-replica error flags produced by the voter and tracks each replica's health with leaky error counters. It retires a replica that misbehaves repeatedly, drives a resync handshake toward the replica-restore logic, and tells the voter to fall back to two-way comparison. When redundancy is exhausted it raises a sticky fatal flag.

---
 rtl/ft_pkg.sv | 5 +
 rtl/cv32e40p_ft_replica_tracker.sv | 83 ++++++++
 rtl/cv32e40p_ft_err_manager.sv | 75 +++++++
 tb/tb_cv32e40p_ft_err_manager.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// ft_pkg: shared types for the fault-tolerance blocks (replica health state, voter error vector)
package ft_pkg;
    typedef enum logic [1:0] {RS_OK, RS_RESYNC, RS_DEAD} replica_state_e;
    typedef logic [2:0] ft_blk_err_t;
endpackage

// File: rtl/cv32e40p_ft_replica_tracker.sv
// cv32e40p_ft_replica_tracker: per-replica leaky error counter, OK/RESYNC/DEAD FSM and resync timeout
// Ports: clk, rst (async, active-high); frz freezes all state; inc/dec bump the counter up/down
// (dec ignored when inc is set); ack restores a replica in RESYNC; cnt is the counter value;
// dis/req/dead are registered state outputs; entering flags an OK->RESYNC move on this edge.
module cv32e40p_ft_replica_tracker
    import ft_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int THRESHOLD = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frz,
    input  logic             inc,
    input  logic             dec,
    input  logic             ack,
    output logic [CNT_W-1:0] cnt,
    output logic             dis,
    output logic             req,
    output logic             dead,
    output logic             entering
);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    replica_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_d, cnt_inc;
    logic [TW-1:0]    tmr_q, tmr_d;

    assign cnt_inc  = &cnt ? cnt : cnt + 1'b1;
    assign entering = !frz && state_q == RS_OK && inc && cnt_inc >= CNT_W'(THRESHOLD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt;
        tmr_d   = tmr_q;
        if (!frz) begin
            case (state_q)
                RS_OK: begin
                    if (inc) begin
                        cnt_d = cnt_inc;
                        if (entering) begin
                            state_d = RS_RESYNC;
                            tmr_d   = '0;
                        end
                    end else if (dec && cnt != '0) begin
                        cnt_d = cnt - 1'b1;
                    end
                end
                RS_RESYNC: begin
                    // ack takes priority over an expiring timer
                    if (ack) begin
                        state_d = RS_OK;
                        cnt_d   = '0;
                    end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                        state_d = RS_DEAD;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RS_OK;
            cnt     <= '0;
            tmr_q   <= '0;
            dis     <= 1'b0;
            req     <= 1'b0;
            dead    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
            tmr_q   <= tmr_d;
            dis     <= state_d != RS_OK;
            req     <= state_d == RS_RESYNC;
            dead    <= state_d == RS_DEAD;
        end
    end
endmodule

// File: rtl/cv32e40p_ft_err_manager.sv
// cv32e40p_ft_err_manager: tracks replica health from voter error flags, retires/resyncs replicas, flags fatal loss of redundancy
// Ports: clk, rst (async, active-high); valid_i qualifies block_err_i (per-replica voter flags);
// resync_ack_i restores replicas; replica_disable_o/resync_req_o/dead_o per-replica status;
// only_two_o selects two-way voting; uncorrectable_o pulses on multi-replica errors;
// fatal_o is sticky; err_cnt_o packs the per-replica counters, replica k at [k*CNT_W +: CNT_W].
module cv32e40p_ft_err_manager
    import ft_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int THRESHOLD = 4,
    parameter int WINDOW    = 256,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [2:0]         block_err_i,
    input  logic [2:0]         resync_ack_i,
    output logic [2:0]         replica_disable_o,
    output logic [2:0]         resync_req_o,
    output logic [2:0]         dead_o,
    output logic               only_two_o,
    output logic               uncorrectable_o,
    output logic               fatal_o,
    output logic [3*CNT_W-1:0] err_cnt_o
);
    localparam int WW = WINDOW > 1 ? $clog2(WINDOW) : 1;

    ft_blk_err_t   masked, inc, dec, entering;
    logic          single, multi, wrap, fatal_set;
    logic [WW-1:0] wcnt_q;

    // errors from already-disabled replicas never count toward classification
    assign masked     = valid_i ? block_err_i & ~replica_disable_o : '0;
    assign single     = masked inside {3'b001, 3'b010, 3'b100};
    assign multi      = masked != '0 && !single;
    assign inc        = single ? masked : '0;
    assign wrap       = valid_i && !fatal_o && wcnt_q == WW'(WINDOW - 1);
    assign dec        = wrap ? ~inc : '0;
    // an entering replica is itself in OK, so any disabled replica is "another" one
    assign fatal_set  = (multi || |entering) && |replica_disable_o;
    assign only_two_o = |replica_disable_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q          <= '0;
            uncorrectable_o <= 1'b0;
            fatal_o         <= 1'b0;
        end else begin
            uncorrectable_o <= multi;
            fatal_o         <= fatal_o | fatal_set;
            if (valid_i && !fatal_o) wcnt_q <= wrap ? '0 : wcnt_q + 1'b1;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_trk
        cv32e40p_ft_replica_tracker #(
            .CNT_W    (CNT_W),
            .THRESHOLD(THRESHOLD),
            .TIMEOUT  (TIMEOUT)
        ) u_trk (
            .clk     (clk),
            .rst     (rst),
            .frz     (fatal_o),
            .inc     (inc[k]),
            .dec     (dec[k]),
            .ack     (resync_ack_i[k]),
            .cnt     (err_cnt_o[k*CNT_W +: CNT_W]),
            .dis     (replica_disable_o[k]),
            .req     (resync_req_o[k]),
            .dead    (dead_o[k]),
            .entering(entering[k])
        );
    end
endmodule

// File: tb/tb_cv32e40p_ft_err_manager.sv
// tb_cv32e40p_ft_err_manager: directed plus randomized check of the error manager against a behavioural model
module tb_cv32e40p_ft_err_manager;
    localparam int CNT_W = 8, TH = 4, WIN = 16, TO = 8;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic               clk = 0, rst = 1, valid = 0;
    logic [2:0]         berr = 0, ack = 0;
    logic [2:0]         dis, req, dead;
    logic               two, unc, fatal;
    logic [3*CNT_W-1:0] cnt;

    int tests = 0, fails = 0;

    // model state: 0 = OK, 1 = RESYNC, 2 = DEAD
    int m_st[3], m_cnt[3], m_ent[3];
    int m_win, m_cyc;
    bit m_unc, m_fatal;

    cv32e40p_ft_err_manager #(.CNT_W(CNT_W), .THRESHOLD(TH), .WINDOW(WIN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid), .block_err_i(berr), .resync_ack_i(ack),
        .replica_disable_o(dis), .resync_req_o(req), .dead_o(dead), .only_two_o(two),
        .uncorrectable_o(unc), .fatal_o(fatal), .err_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_ent[k] = 0;
        end
        m_win = 0; m_unc = 0; m_fatal = 0;
    endfunction

    function automatic void m_step();
        int  n;
        bit  any_dis, wrap, nf;
        bit [2:0] m;
        any_dis = 0;
        for (int k = 0; k < 3; k++) if (m_st[k] != 0) any_dis = 1;
        m = 0;
        for (int k = 0; k < 3; k++) if (valid && berr[k] && m_st[k] == 0) m[k] = 1;
        n = m[0] + m[1] + m[2];
        m_unc = n >= 2;
        if (m_fatal) return;
        nf = m_unc && any_dis;
        wrap = valid && m_win == WIN - 1;
        if (valid) m_win = (m_win + 1) % WIN;
        for (int k = 0; k < 3; k++) begin
            if (m_st[k] == 0) begin
                if (n == 1 && m[k]) begin
                    m_cnt[k] = m_cnt[k] < CMAX ? m_cnt[k] + 1 : CMAX;
                    if (m_cnt[k] >= TH) begin
                        m_st[k] = 1; m_ent[k] = m_cyc;
                        if (any_dis) nf = 1;
                    end
                end else if (wrap && m_cnt[k] > 0) m_cnt[k]--;
            end else if (m_st[k] == 1) begin
                if (ack[k]) begin
                    m_st[k] = 0; m_cnt[k] = 0;
                end else if (m_cyc - m_ent[k] >= TO) m_st[k] = 2;
            end
        end
        m_fatal = m_fatal | nf;
    endfunction

    // per-cycle compare of every output against the model
    initial begin
        logic [2:0] ed, er, edd;
        logic [3*CNT_W-1:0] ec;
        m_cyc = 0;
        forever begin
            @(posedge clk);
            m_cyc++;
            #1;
            if (rst) m_reset(); else m_step();
            for (int k = 0; k < 3; k++) begin
                ed[k]  = m_st[k] != 0;
                er[k]  = m_st[k] == 1;
                edd[k] = m_st[k] == 2;
                ec[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
            end
            chk("m_disable", 32'(dis), 32'(ed));
            chk("m_req", 32'(req), 32'(er));
            chk("m_dead", 32'(dead), 32'(edd));
            chk("m_only_two", 32'(two), 32'(|ed));
            chk("m_unc", 32'(unc), 32'(m_unc));
            chk("m_fatal", 32'(fatal), 32'(m_fatal));
            chk("m_cnt", 32'(cnt), 32'(ec));
        end
    end

    task automatic tick(input logic v, input logic [2:0] b, input logic [2:0] a);
        @(negedge clk);
        valid = v; berr = b; ack = a;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; valid = 0; berr = 0; ack = 0;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 20; i++) tick(0, 0, 0);
        chk("idle_outs", {dis, req, dead, two, unc, fatal}, 0);
        chk("idle_cnt", 32'(cnt), 0);

        for (int i = 1; i <= 4; i++) begin
            tick(1, 3'b010, 0);
            chk("cnt1_ramp", 32'(cnt[15:8]), 32'(i));
        end
        chk("ret_dis", 32'(dis), 32'b010);
        chk("ret_req", 32'(req), 32'b010);
        chk("ret_two", 32'(two), 1);
        tick(0, 0, 3'b010);
        chk("ack_dis_req", {dis, req}, 0);
        chk("ack_cnt1", 32'(cnt[15:8]), 0);

        for (int i = 0; i < 4; i++) tick(1, 3'b010, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 0);
        chk("dead_dead", 32'(dead), 32'b010);
        chk("dead_req", 32'(req), 0);
        chk("dead_dis", 32'(dis), 32'b010);
        for (int i = 0; i < 4; i++) tick(1, 3'b001, 0);
        chk("fatal_set", 32'(fatal), 1);
        for (int i = 0; i < 3; i++) tick(1, 3'b001, 3'b001);
        chk("fatal_sticky", 32'(fatal), 1);
        chk("fatal_frozen_dis", 32'(dis), 32'b011);
        do_reset();
        tick(0, 0, 0);
        chk("fatal_rst", 32'(fatal), 0);

        do_reset();
        tick(1, 3'b100, 0);
        for (int i = 0; i < 16; i++) tick(1, 0, 0);
        chk("leak_cnt2", 32'(cnt[23:16]), 0);
        do_reset();
        tick(1, 3'b100, 0);
        for (int i = 0; i < 14; i++) tick(1, 0, 0);
        tick(1, 3'b100, 0);
        chk("leak_inc_wins", 32'(cnt[23:16]), 2);

        tick(1, 3'b111, 0);
        chk("unc_pulse", 32'(unc), 1);
        chk("unc_cnt_hold", 32'(cnt), 32'h020000);
        tick(0, 0, 0);
        chk("unc_one_cycle", 32'(unc), 0);
        tick(0, 3'b111, 0);
        chk("unc_invalid", 32'(unc), 0);

        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 3'b001, 0);
        chk("pre_async_req", 32'(req), 32'b001);
        @(negedge clk);
        #1 rst = 1;
        #1;
        chk("async_req", 32'(req), 0);
        chk("async_dis", 32'(dis), 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [2:0] b, a;
            r = $urandom_range(0, 9);
            b = r < 5 ? 3'b000 : r < 8 ? 3'(1 << $urandom_range(0, 2)) : r == 8 ? 3'($urandom_range(0, 7)) : 3'b000;
            a = $urandom_range(0, 5) == 0 ? 3'($urandom_range(0, 7)) : 3'b000;
            tick(1'($urandom_range(0, 3) != 0), b, a);
            if (i % 150 == 149 && m_fatal) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
